// File: rtl/cordic_out_stage_if.sv
// Handshake bundle between the CORDIC output stage and its upstream/downstream.
// master: upstream source + core results + consumer; slave: cordic_out_stage.
interface cordic_out_stage_if #(
    parameter int unsigned IN_W  = 17,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  core_x;
    logic signed [IN_W-1:0]  core_y;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_x;
    logic signed [OUT_W-1:0] out_y;
    logic [LVL_W-1:0]        level;

    modport master (
        output in_valid, core_x, core_y, out_ready,
        input  in_ready, out_valid, out_x, out_y, level
    );

    modport slave (
        input  in_valid, core_x, core_y, out_ready,
        output in_ready, out_valid, out_x, out_y, level
    );
endinterface

// File: rtl/cordic_out_stage.sv
// CORDIC output stage: token tracking, gain removal, rounding and credit-managed FIFO.
// Optional macro CORDIC_OUT_SAT_EN: saturate instead of wrap and keep a sticky sat_seen flag.
module cordic_out_stage #(
    parameter int unsigned IN_W     = 17,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned CORE_LAT = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned INV_K    = 19899
) (
    input  logic               clock,
    input  logic               reset_n,
    cordic_out_stage_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = IN_W + 16;
    localparam int unsigned CW = $clog2(CORE_LAT + DEPTH + 3) + 1;
    localparam logic signed [PW-1:0] K_S = PW'(INV_K);
    localparam logic signed [PW-1:0] RND = PW'(1 << 14);

    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_ovalid_nxt;
    logic [AW:0]             w_rd_nxt;
    logic [AW:0]             w_level;
    logic signed [OUT_W-1:0] w_nx;
    logic signed [OUT_W-1:0] w_ny;

    logic [CORE_LAT-1:0]     r_tok;
    logic                    r_m_valid;
    logic                    r_r_valid;
    logic [CW-1:0]           r_inflight;
    logic signed [PW-1:0]    r_px;
    logic signed [PW-1:0]    r_py;
    logic signed [OUT_W-1:0] r_rx;
    logic signed [OUT_W-1:0] r_ry;
    logic [AW:0]             r_wr_ptr;
    logic [AW:0]             r_rd_ptr;
    logic signed [OUT_W-1:0] r_mem_x [DEPTH];
    logic signed [OUT_W-1:0] r_mem_y [DEPTH];
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_x;
    logic signed [OUT_W-1:0] r_out_y;

    function automatic logic signed [PW-1:0] round_q15(input logic signed [PW-1:0] p);
        return (p + RND) >>> 15;
    endfunction

    // Credits cover everything already accepted but not yet popped, so a push can never find the FIFO full.
    assign w_level      = r_wr_ptr - r_rd_ptr;
    assign bus.in_ready = (CW'(w_level) + r_inflight) < CW'(DEPTH);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_push       = r_r_valid;
    assign w_pop        = r_out_valid && bus.out_ready;
    assign w_rd_nxt     = r_rd_ptr + (AW+1)'(w_pop);
    // Entries written this edge are not yet visible to the head register.
    assign w_ovalid_nxt = (r_wr_ptr != w_rd_nxt);

`ifdef CORDIC_OUT_SAT_EN
    localparam logic signed [PW-1:0] SAT_HI = PW'((1 << (OUT_W-1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

    logic signed [PW-1:0] w_rx_full;
    logic signed [PW-1:0] w_ry_full;
    logic                 w_clip;
    logic                 sat_seen;

    always_comb begin
        w_rx_full = round_q15(r_px);
        w_ry_full = round_q15(r_py);
        w_nx      = OUT_W'(w_rx_full);
        w_ny      = OUT_W'(w_ry_full);
        w_clip    = 1'b0;
        if (w_rx_full > SAT_HI) begin
            w_nx   = OUT_W'(SAT_HI);
            w_clip = 1'b1;
        end else if (w_rx_full < SAT_LO) begin
            w_nx   = OUT_W'(SAT_LO);
            w_clip = 1'b1;
        end
        if (w_ry_full > SAT_HI) begin
            w_ny   = OUT_W'(SAT_HI);
            w_clip = 1'b1;
        end else if (w_ry_full < SAT_LO) begin
            w_ny   = OUT_W'(SAT_LO);
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                  sat_seen <= 1'b0;
        else if (r_m_valid && w_clip)  sat_seen <= 1'b1;
    end
`else
    assign w_nx = OUT_W'(round_q15(r_px));
    assign w_ny = OUT_W'(round_q15(r_py));
`endif

    // Token line and stage valids; in-flight count drops when stage R writes the FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tok      <= '0;
            r_m_valid  <= 1'b0;
            r_r_valid  <= 1'b0;
            r_inflight <= '0;
        end else begin
            r_tok      <= {r_tok[CORE_LAT-2:0], w_accept};
            r_m_valid  <= r_tok[CORE_LAT-1];
            r_r_valid  <= r_m_valid;
            r_inflight <= r_inflight + CW'(w_accept) - CW'(w_push);
        end
    end

    always_ff @(posedge clock) begin
        if (r_tok[CORE_LAT-1]) begin
            r_px <= PW'(bus.core_x) * K_S;
            r_py <= PW'(bus.core_y) * K_S;
        end
        if (r_m_valid) begin
            r_rx <= w_nx;
            r_ry <= w_ny;
        end
        if (w_push) begin
            r_mem_x[r_wr_ptr[AW-1:0]] <= r_rx;
            r_mem_y[r_wr_ptr[AW-1:0]] <= r_ry;
        end
    end

    // Pointers and registered head; head holds its value when nothing new is available.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + (AW+1)'(w_push);
            r_rd_ptr    <= w_rd_nxt;
            r_out_valid <= w_ovalid_nxt;
            if (w_ovalid_nxt) begin
                r_out_x <= r_mem_x[w_rd_nxt[AW-1:0]];
                r_out_y <= r_mem_y[w_rd_nxt[AW-1:0]];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_x     = r_out_x;
    assign bus.out_y     = r_out_y;
    assign bus.level     = w_level;
endmodule

// File: tb/tb_cordic_out_stage.sv
// Randomized bench for cordic_out_stage with an ideal-core model and an occupancy/credit scoreboard.
module tb_cordic_out_stage;
    localparam int unsigned IN_W     = 17;
    localparam int unsigned OUT_W    = 16;
    localparam int unsigned CORE_LAT = 16;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned INV_K    = 19899;
    localparam int          LAT      = CORE_LAT + 2;
    localparam real         K_GAIN   = 1.646760258;
    localparam real         TWO_PI   = 6.283185307179586;

    logic clock;
    logic reset_n;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    cordic_out_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    cordic_out_stage #(
        .IN_W(IN_W), .OUT_W(OUT_W), .CORE_LAT(CORE_LAT), .DEPTH(DEPTH), .INV_K(INV_K)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int pops   = 0;
    int acc_edge [$];
    int qx [$];
    int qy [$];
    int last_x, last_y;

    logic [31:0] ang;
    int xin, yin;
    int cx, cy;
    logic signed [IN_W-1:0] pipe_x [CORE_LAT];
    logic signed [IN_W-1:0] pipe_y [CORE_LAT];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd_int(input real r);
        int v;
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        if (v > 65535)  v = 65535;
        if (v < -65536) v = -65536;
        return v;
    endfunction

    // Ideal rotator: gain K, angle as a 32-bit fraction of a full turn.
    function automatic void core_fn(input logic [31:0] a, input int x, input int y,
                                    output int ox, output int oy);
        real th;
        th = real'(a) * TWO_PI / 4294967296.0;
        ox = rnd_int(K_GAIN * (real'(x) * $cos(th) - real'(y) * $sin(th)));
        oy = rnd_int(K_GAIN * (real'(x) * $sin(th) + real'(y) * $cos(th)));
    endfunction

    function automatic int expo(input int c);
        longint r;
        r = (longint'(c) * longint'(INV_K) + 64'sd16384) >>> 15;
`ifdef CORDIC_OUT_SAT_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`else
        r = r & 64'hFFFF;
        if (r >= 32768) r = r - 65536;
`endif
        return int'(r);
    endfunction

    function automatic int writes_through(input int k);
        int n;
        n = 0;
        foreach (acc_edge[i]) if (acc_edge[i] + LAT <= k) n++;
        return n;
    endfunction

    always @(posedge clock) begin
        core_fn(ang, xin, yin, cx, cy);
        pipe_x[0] <= IN_W'(cx);
        pipe_y[0] <= IN_W'(cy);
        for (int i = 1; i < CORE_LAT; i++) begin
            pipe_x[i] <= pipe_x[i-1];
            pipe_y[i] <= pipe_y[i-1];
        end
    end
    assign bus.core_x = pipe_x[CORE_LAT-1];
    assign bus.core_y = pipe_y[CORE_LAT-1];

    // One cycle from a negedge to the next: check, decide transfers, drive, update model.
    task automatic step(input bit v, input logic [31:0] a, input int x, input int y, input bit rdy);
        int  kx, ky;
        bit  acc, pop;
        check("level", bus.level, writes_through(edge_n) - pops);
        check("out_valid", bus.out_valid, (writes_through(edge_n - 1) > pops) ? 1 : 0);
        check("in_ready", bus.in_ready, ((acc_edge.size() - pops) < DEPTH) ? 1 : 0);
        acc = v && bus.in_ready;
        pop = bus.out_valid && rdy;
        if (pop) begin
            last_x = bus.out_x;
            last_y = bus.out_y;
            if (qx.size() == 0) begin
                check("pop_unexpected", 1, 0);
            end else begin
                check("out_x", bus.out_x, qx[0]);
                check("out_y", bus.out_y, qy[0]);
                void'(qx.pop_front());
                void'(qy.pop_front());
            end
        end
        bus.in_valid  = v;
        bus.out_ready = rdy;
        ang = a;
        xin = x;
        yin = y;
        @(posedge clock);
        edge_n++;
        if (acc) begin
            core_fn(a, x, y, kx, ky);
            acc_edge.push_back(edge_n);
            qx.push_back(expo(kx));
            qy.push_back(expo(ky));
        end
        if (pop) pops++;
        @(negedge clock);
    endtask

    task automatic single(input string tag, input logic [31:0] a, input int x, input int y,
                          input int nomx, input int nomy);
        int lat, e0;
        bit inx, iny;
        lat = -1;
        step(1'b1, a, x, y, 1'b1);
        e0 = edge_n;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid && lat < 0) lat = edge_n - e0;
            step(1'b0, 32'h0, 0, 0, 1'b1);
        end
        check({tag, "_latency"}, lat, CORE_LAT + 3);
        inx = (last_x >= nomx - 2) && (last_x <= nomx + 2);
        iny = (last_y >= nomy - 2) && (last_y <= nomy + 2);
        check($sformatf("%s_x_near_%0d(got %0d)", tag, nomx, last_x), inx, 1);
        check($sformatf("%s_y_near_%0d(got %0d)", tag, nomy, last_y), iny, 1);
    endtask

    function automatic int rvec();
        return int'($urandom_range(54000)) - 27000;
    endfunction

    initial begin
        int cnt, p0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        ang = '0; xin = 0; yin = 0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_level", bus.level, 0);
        check("rst_out_x", bus.out_x, 0);
        check("rst_out_y", bus.out_y, 0);
        reset_n = 1'b1;
        repeat (40) step(1'b0, $urandom, rvec(), rvec(), 1'b1);

        single("ang0",   32'h0000_0000, 16384, 0, 16384, 0);
        single("ang90",  32'h4000_0000, 16384, 0, 0, 16384);
        single("ang270", 32'hC000_0000, 16384, 0, 0, -16384);
`ifdef CORDIC_OUT_SAT_EN
        check("sat_seen_clear", u_dut.sat_seen, 0);
        single("ang45", 32'h2000_0000, 25000, -25000, 32767, 0);
        check("sat_seen_set", u_dut.sat_seen, 1);
`else
        single("ang45", 32'h2000_0000, 25000, -25000, -30181, 0);
`endif

        // Fill with the consumer stalled, then drain.
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready) cnt++;
            step(1'b1, $urandom, rvec(), rvec(), 1'b0);
        end
        check("fill_accepts", cnt, DEPTH);
        check("fill_level", bus.level, DEPTH);
        check("fill_in_ready", bus.in_ready, 0);
        p0 = pops;
        check("ready_at_first_pop", bus.in_ready, 0);
        step(1'b0, 32'h0, 0, 0, 1'b1);
        check("ready_after_first_pop", bus.in_ready, 1);
        repeat (20) step(1'b0, 32'h0, 0, 0, 1'b1);
        check("drain_pops", pops - p0, DEPTH);

        // Randomized traffic with varying consumer pressure.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 10) < 6, $urandom, rvec(), rvec(),
                 ($urandom % 10) < ((i < 750) ? 3 : 8));
        end
        repeat (40) step(1'b0, 32'h0, 0, 0, 1'b1);
        check("scoreboard_empty", qx.size(), 0);

        // Asynchronous reset with results both in flight and buffered.
        repeat (3) step(1'b1, $urandom, rvec(), rvec(), 1'b0);
        repeat (20) step(1'b0, 32'h0, 0, 0, 1'b0);
        repeat (5) step(1'b1, $urandom, rvec(), rvec(), 1'b0);
        check("pre_rst_level", bus.level, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_level", bus.level, 0);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_out_x", bus.out_x, 0);
        check("arst_out_y", bus.out_y, 0);
`ifdef CORDIC_OUT_SAT_EN
        check("arst_sat_seen", u_dut.sat_seen, 0);
`endif
        acc_edge.delete();
        qx.delete();
        qy.delete();
        pops = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) step(1'b0, 32'h0, 0, 0, 1'b1);
        single("post_rst", 32'h0000_0000, 16384, 0, 16384, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
